// File: rtl/ysyx_22040127_wb_pkg.sv
// Shared widths and load funct3 encodings for the writeback unit.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ysyx_22040127_wb_pkg;

    localparam int WB_DATA_WIDTH = 64;
    localparam int WB_ADDR_WIDTH = 5;

    // RISC-V load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/ysyx_22040127_load_ext.sv
// Aligns a raw load doubleword by its byte offset and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs every cycle.
module ysyx_22040127_load_ext
    import ysyx_22040127_wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic [63:0]           rdata_i,
    input  logic [2:0]            addr_lo_i,
    input  logic [2:0]            funct3_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  bad_o
);

    logic [63:0] shifted;

    // Byte lane select: the addressed byte lands in bits [7:0].
    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    // Width select and extension; the unused funct3 code returns zero and flags it.
    always_comb begin
        data_o = '0;
        bad_o  = 1'b0;
        case (funct3_i)
            F3_LB:   data_o = {{(DATA_WIDTH-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   data_o = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   data_o = shifted[DATA_WIDTH-1:0];
            F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}},  shifted[7:0]};
            F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            F3_LWU:  data_o = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
            default: bad_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_22040127_wbu.sv
// Writeback unit: arbitrates load responses and ALU results onto one regfile write port, tracks in-flight loads.
// Latency: one cycle from acceptance to wen/waddr/wdata.
// Backpressure: load responses always win; exu_ready drops on a load response or busy rd, iss_ready drops on busy rd.
module ysyx_22040127_wbu
    import ysyx_22040127_wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // ALU result channel
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    // load response channel, always accepted
    input  logic                  lsu_valid,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [63:0]           lsu_rdata,
    input  logic [2:0]            lsu_addr_lo,
    input  logic [2:0]            lsu_funct3,
    // load issue notification
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    // operand hazard query
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  hazard1,
    output logic                  hazard2,
    // register-file write port
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    // status
    output logic [63:0]           retire_cnt,
    output logic                  err
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy_q, busy_d;
    logic                  err_q, err_d;
    logic [63:0]           retire_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_bad;
    logic                  iss_fire, exu_fire, acc;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_dat;

    ysyx_22040127_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .rdata_i   (lsu_rdata),
        .addr_lo_i (lsu_addr_lo),
        .funct3_i  (lsu_funct3),
        .data_o    (ld_data),
        .bad_o     (ld_bad)
    );

    // Handshakes; no load-response bypass, so a clearing rd still reads busy this cycle.
    assign iss_ready = !busy_q[iss_rd] || (iss_rd == '0);
    assign exu_ready = !lsu_valid && !(busy_q[exu_rd] && (exu_rd != '0));
    assign hazard1   = busy_q[raddr1] && (raddr1 != '0);
    assign hazard2   = busy_q[raddr2] && (raddr2 != '0);

    assign iss_fire = iss_valid && iss_ready;
    assign exu_fire = exu_valid && exu_ready;
    assign acc      = lsu_valid || exu_fire;
    assign sel_rd   = lsu_valid ? lsu_rd  : exu_rd;
    assign sel_dat  = lsu_valid ? ld_data : exu_wdata;

    // Scoreboard next state: clear on response, then set on issue so a same-rd issue wins.
    always_comb begin
        busy_d = busy_q;
        if (lsu_valid) begin
            busy_d[lsu_rd] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Sticky error: response without a matching in-flight load, or an undefined load width.
    always_comb begin
        err_d = err_q;
        if (lsu_valid && (lsu_rd != '0) && !busy_q[lsu_rd]) begin
            err_d = 1'b1;
        end
        if (lsu_valid && ld_bad) begin
            err_d = 1'b1;
        end
    end

    // State and registered write port; wen pulses once per accepted write to a non-zero rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            err_q    <= 1'b0;
            retire_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            if (acc) begin
                wen_q    <= (sel_rd != '0);
                waddr_q  <= sel_rd;
                wdata_q  <= sel_dat;
                retire_q <= retire_q + 64'd1;
            end else begin
                wen_q    <= 1'b0;
            end
        end
    end

    assign wen        = wen_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign retire_cnt = retire_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ysyx_22040127_wbu.sv
// Self-checking bench for the writeback unit: directed scenarios plus random traffic against a reference model.
// Latency: model expects writes one cycle after acceptance.
// Backpressure: model derives exu_ready/iss_ready from its own in-flight load set.
module tb_ysyx_22040127_wbu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_wdata;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_rdata;
    logic [2:0]  lsu_addr_lo, lsu_funct3;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rd;
    logic [4:0]  raddr1, raddr2;
    logic        hazard1, hazard2;
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] retire_cnt;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit [31:0]   m_busy;
    bit          m_err;
    logic [63:0] m_retire;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata;

    ysyx_22040127_wbu dut (
        .clk(clk), .rst_n(rst_n),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_wdata(exu_wdata),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata),
        .lsu_addr_lo(lsu_addr_lo), .lsu_funct3(lsu_funct3),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .retire_cnt(retire_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load result from the architectural rule: take size bytes at offset, then extend.
    function automatic logic [63:0] ref_load(input logic [63:0] raw, input logic [2:0] lo,
                                             input logic [2:0] f3);
        logic [63:0] v, mask;
        int nb;
        if (f3 == 3'b111) return 64'd0;
        v    = raw >> (8 * lo);
        nb   = 1 << f3[1:0];
        mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
        v    = v & mask;
        if (!f3[2] && nb < 8 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle();
        exu_valid = 1'b0; exu_rd = '0; exu_wdata = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_rdata = '0; lsu_addr_lo = '0; lsu_funct3 = '0;
        iss_valid = 1'b0; iss_rd = '0;
        raddr1 = '0; raddr2 = '0;
    endtask

    // One clock with current inputs; entered and left just after a falling edge.
    task automatic step();
        bit          er, ir, acc;
        logic [4:0]  rd;
        logic [63:0] d;
        rd = '0; d = '0; acc = 1'b0;
        #1;
        er = !lsu_valid && !(exu_rd != 0 && m_busy[exu_rd]);
        ir = (iss_rd == 0) || !m_busy[iss_rd];
        chk("exu_ready", exu_ready, er);
        chk("iss_ready", iss_ready, ir);
        chk("hazard1", hazard1, raddr1 != 0 && m_busy[raddr1]);
        chk("hazard2", hazard2, raddr2 != 0 && m_busy[raddr2]);
        if (lsu_valid) begin
            acc = 1'b1; rd = lsu_rd;
            d = ref_load(lsu_rdata, lsu_addr_lo, lsu_funct3);
            if ((lsu_rd != 0 && !m_busy[lsu_rd]) || lsu_funct3 == 3'b111) m_err = 1'b1;
        end else if (exu_valid && er) begin
            acc = 1'b1; rd = exu_rd; d = exu_wdata;
        end
        if (lsu_valid) m_busy[lsu_rd] = 1'b0;
        if (iss_valid && ir && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        m_wen = acc && rd != 0;
        if (acc) begin
            m_waddr = rd; m_wdata = d; m_retire = m_retire + 64'd1;
        end
        @(posedge clk);
        #1;
        chk("wen", wen, m_wen);
        chk("retire_cnt", retire_cnt, m_retire);
        chk("err", err, m_err);
        if (m_wen) begin
            chk("waddr", waddr, m_waddr);
            chk("wdata", wdata, m_wdata);
        end
        @(negedge clk);
    endtask

    // Assert reset asynchronously and check outputs clear before any clock edge.
    task automatic do_reset();
        set_idle();
        raddr1 = 5'd7;
        rst_n = 1'b0;
        #1;
        chk("rst_wen", wen, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_err", err, 0);
        chk("rst_hazard1", hazard1, 0);
        chk("rst_exu_ready", exu_ready, 1);
        chk("rst_iss_ready", iss_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        m_busy = '0; m_err = 1'b0; m_retire = '0; m_wen = 1'b0;
        set_idle();
    endtask

    task automatic issue(input logic [4:0] rd);
        set_idle(); iss_valid = 1'b1; iss_rd = rd; step();
    endtask

    task automatic exu_wr(input logic [4:0] rd, input logic [63:0] d);
        set_idle(); exu_valid = 1'b1; exu_rd = rd; exu_wdata = d; step();
    endtask

    task automatic load_case(input string tag, input logic [2:0] lo, input logic [2:0] f3,
                             input logic [63:0] exp);
        issue(5'd10);
        set_idle();
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_rdata = 64'h8877665544332211;
        lsu_addr_lo = lo; lsu_funct3 = f3;
        step();
        chk(tag, wdata, exp);
    endtask

    initial begin
        logic [4:0] r;
        set_idle();
        #2;
        do_reset();

        // single ALU writeback
        exu_wr(5'd5, 64'h1234);
        chk("t1_waddr", waddr, 5);
        chk("t1_wdata", wdata, 64'h1234);
        chk("t1_retire", retire_cnt, 1);

        // load-use hazard held until the response, released the cycle after
        issue(5'd7);
        set_idle(); exu_valid = 1'b1; exu_rd = 5'd7; raddr1 = 5'd7;
        #1; chk("t2_exu_ready_busy", exu_ready, 0); chk("t2_hazard1", hazard1, 1);
        step();
        set_idle(); exu_valid = 1'b1; exu_rd = 5'd7; raddr1 = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_rdata = 64'h55; lsu_funct3 = 3'b011;
        #1; chk("t2_hazard1_resp", hazard1, 1);
        step();
        set_idle(); exu_valid = 1'b1; exu_rd = 5'd7; raddr1 = 5'd7;
        #1; chk("t2_exu_ready_free", exu_ready, 1); chk("t2_hazard1_free", hazard1, 0);
        step();

        // load alignment and extension
        load_case("t3_lh",  3'd6, 3'b001, 64'hFFFFFFFFFFFF8877);
        load_case("t3_lhu", 3'd6, 3'b101, 64'h0000000000008877);
        load_case("t3_lw",  3'd4, 3'b010, 64'hFFFFFFFF88776655);

        // simultaneous load response and ALU result
        issue(5'd3);
        set_idle(); exu_valid = 1'b1; exu_rd = 5'd4; exu_wdata = 64'hABCD;
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_rdata = 64'h99; lsu_funct3 = 3'b100;
        #1; chk("t4_exu_ready", exu_ready, 0);
        step();
        chk("t4_first_waddr", waddr, 3);
        set_idle(); exu_valid = 1'b1; exu_rd = 5'd4; exu_wdata = 64'hABCD;
        step();
        chk("t4_second_waddr", waddr, 4);
        chk("t4_second_wdata", wdata, 64'hABCD);

        // random traffic with well-formed load responses
        for (int i = 0; i < 400; i++) begin
            set_idle();
            exu_valid = 1'($urandom_range(0, 1));
            exu_rd    = 5'($urandom);
            exu_wdata = {$urandom, $urandom};
            iss_valid = ($urandom_range(0, 9) < 3);
            iss_rd    = 5'($urandom);
            raddr1    = 5'($urandom);
            raddr2    = 5'($urandom);
            if (m_busy != 0 && $urandom_range(0, 9) < 4) begin
                do r = 5'($urandom); while (!m_busy[r]);
                lsu_valid   = 1'b1;
                lsu_rd      = r;
                lsu_rdata   = {$urandom, $urandom};
                lsu_addr_lo = 3'($urandom);
                lsu_funct3  = 3'($urandom_range(0, 6));
            end
            step();
        end

        // rd=0 write is suppressed but retired; stray response raises sticky err
        exu_wr(5'd0, 64'hDEAD);
        chk("t5_wen_rd0", wen, 0);
        set_idle(); exu_valid = 1'b1;
        #1; chk("t5_exu_ready_rd0", exu_ready, 1);
        step();
        if (m_busy[9]) begin
            set_idle(); lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = 3'b011; step();
        end
        set_idle(); lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_funct3 = 3'b011;
        step();
        chk("t5_err_set", err, 1);
        set_idle(); step();
        chk("t5_err_sticky", err, 1);

        // asynchronous reset mid-cycle with a load in flight
        do_reset();
        issue(5'd7);
        exu_wr(5'd1, 64'h1);
        exu_wr(5'd2, 64'h2);
        exu_wr(5'd3, 64'h3);
        chk("t6_pre_retire", retire_cnt, 3);
        set_idle(); raddr1 = 5'd7;
        #1; chk("t6_pre_hazard", hazard1, 1);
        #1;
        do_reset();

        // response for a pre-reset load: flagged, still written
        set_idle(); lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_rdata = 64'h1122; lsu_funct3 = 3'b011;
        step();
        chk("t7_err", err, 1);
        chk("t7_waddr", waddr, 7);
        chk("t7_wdata", wdata, 64'h1122);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
